// File: rtl/logic_op_pkg.sv
// Shared opcode encodings, widths and FSM state type for the logic-op arbiter.
package logic_op_pkg;

  localparam int OP_W  = 3;
  localparam int CNT_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise evaluator; the reserved opcode yields zero plus an error flag.
module logic_op_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOT:  y = ~a;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter over NREQ requesters feeding one logic-op unit and a
// single-entry output register with valid/ready handshake.
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [NREQ-1:0]       req_valid_in,
  output logic [NREQ-1:0]       req_ready_out,
  input  logic [OP_W*NREQ-1:0]  req_op_in,
  input  logic [WIDTH*NREQ-1:0] req_a_in,
  input  logic [WIDTH*NREQ-1:0] req_b_in,
  output logic                  res_valid_out,
  input  logic                  res_ready_in,
  output logic [WIDTH-1:0]      res_data_out,
  output logic [IDW-1:0]        res_id_out,
  output logic                  res_err_out,
  output logic [CNT_W-1:0]      op_count_out
);

  state_e           state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win;
  logic             found;
  logic             accept;
  logic             grant;
  logic [OP_W-1:0]  op_sel;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH-1:0] y;
  logic             err;

  assign accept = (state == ST_EMPTY) || res_ready_in;
  // Gated by reset so no grant is visible while the block is held in reset.
  assign grant  = accept && found && rst_n_in;

  // First valid requester at or above rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid_in[idx]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  assign op_sel = req_op_in[win*OP_W +: OP_W];
  assign a_sel  = req_a_in[win*WIDTH +: WIDTH];
  assign b_sel  = req_b_in[win*WIDTH +: WIDTH];

  logic_op_unit #(.WIDTH(WIDTH)) u_unit (
    .op  (op_sel),
    .a   (a_sel),
    .b   (b_sel),
    .y   (y),
    .err (err)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= ST_EMPTY;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (grant)             state_nxt = ST_FULL;
    else if (res_ready_in) state_nxt = ST_EMPTY;
  end

  always_comb begin
    res_valid_out = (state == ST_FULL);
    req_ready_out = grant ? (NREQ'(1) << win) : '0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      res_data_out <= '0;
      res_id_out   <= '0;
      res_err_out  <= 1'b0;
      rr_ptr       <= '0;
    end else if (grant) begin
      res_data_out <= y;
      res_id_out   <= win;
      res_err_out  <= err;
      rr_ptr       <= (win == IDW'(NREQ-1)) ? '0 : win + IDW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                          op_count_out <= '0;
    else if (res_valid_out && res_ready_in) op_count_out <= op_count_out + CNT_W'(1);
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench: a reference model predicts grants and pushes expected results
// to a scoreboard queue, popped when the DUT hands a result over.
module tb_logic_op_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       id;
    logic             err;
  } exp_t;

  logic                  clk, rst_n;
  logic [NREQ-1:0]       req_valid_in, req_ready_out;
  logic [3*NREQ-1:0]     req_op_in;
  logic [WIDTH*NREQ-1:0] req_a_in, req_b_in;
  logic                  res_valid_out, res_ready_in, res_err_out;
  logic [WIDTH-1:0]      res_data_out;
  logic [1:0]            res_id_out;
  logic [15:0]           op_count_out;

  logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .req_valid_in  (req_valid_in),
    .req_ready_out (req_ready_out),
    .req_op_in     (req_op_in),
    .req_a_in      (req_a_in),
    .req_b_in      (req_b_in),
    .res_valid_out (res_valid_out),
    .res_ready_in  (res_ready_in),
    .res_data_out  (res_data_out),
    .res_id_out    (res_id_out),
    .res_err_out   (res_err_out),
    .op_count_out  (op_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  exp_t        sb[$];
  int          gq[$];
  int          m_ptr = 0;
  logic        m_full = 1'b0;
  logic [15:0] m_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_op(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, ~a};
      3'd3: return {1'b0, ~(a & b)};
      3'd4: return {1'b0, ~(a | b)};
      3'd5: return {1'b0, a ^ b};
      3'd6: return {1'b0, ~(a ^ b)};
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  task automatic set_req(input int i, input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_op_in[3*i +: 3]         = op;
    req_a_in[WIDTH*i +: WIDTH]  = a;
    req_b_in[WIDTH*i +: WIDTH]  = b;
  endtask

  // One clock: check at negedge against the model, then advance to posedge+1.
  task automatic step();
    int          win;
    logic [3:0]  exp_rdy;
    logic [WIDTH:0] r;
    exp_t        e;
    @(negedge clk);
    win = -1;
    if (!m_full || res_ready_in)
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && req_valid_in[idx]) win = idx;
      end
    exp_rdy = (win >= 0) ? (4'b0001 << win) : 4'b0000;
    chk("req_ready", 32'(req_ready_out), 32'(exp_rdy));
    chk("res_valid", 32'(res_valid_out), 32'(m_full));
    chk("op_count", 32'(op_count_out), 32'(m_cnt));
    if (m_full) begin
      e = sb[0];
      chk("res_data", 32'(res_data_out), 32'(e.data));
      chk("res_id", 32'(res_id_out), 32'(e.id));
      chk("res_err", 32'(res_err_out), 32'(e.err));
      if (res_ready_in) begin
        void'(sb.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
    end
    if (win >= 0) begin
      r = ref_op(req_op_in[3*win +: 3], req_a_in[WIDTH*win +: WIDTH], req_b_in[WIDTH*win +: WIDTH]);
      e.data = r[WIDTH-1:0];
      e.id   = 2'(win);
      e.err  = r[WIDTH];
      sb.push_back(e);
      gq.push_back(win);
      m_ptr = (win + 1) % NREQ;
    end
    m_full = (win >= 0) || (m_full && !res_ready_in);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_order[5];
    int guard;
    rst_n = 1'b0; res_ready_in = 1'b0;
    req_valid_in = 4'b0001; req_op_in = '0; req_a_in = '0; req_b_in = '0;
    #3;
    chk("rst_valid", 32'(res_valid_out), 0);
    chk("rst_ready", 32'(req_ready_out), 0);
    chk("rst_data", 32'(res_data_out), 0);
    chk("rst_id", 32'(res_id_out), 0);
    chk("rst_err", 32'(res_err_out), 0);
    chk("rst_count", 32'(op_count_out), 0);
    @(posedge clk); #1;
    req_valid_in = '0;
    rst_n = 1'b1;

    // AND on requester 0
    set_req(0, 3'd0, 8'hF0, 8'h3C); req_valid_in = 4'b0001; res_ready_in = 1'b1;
    step();
    req_valid_in = '0;
    chk("and_data", 32'(res_data_out), 32'h30);
    chk("and_id", 32'(res_id_out), 0);
    step(); step();
    chk("and_count", 32'(op_count_out), 1);

    // sparse requesters skip idle slots: pointer is 1 here
    set_req(1, 3'd3, 8'hC3, 8'h0F); set_req(3, 3'd4, 8'h11, 8'h22);
    req_valid_in = 4'b1010; gq.delete();
    repeat (4) step();
    req_valid_in = '0;
    exp_order = '{1, 3, 1, 3, 0};
    for (int i = 0; i < 4; i++) chk("sparse_order", 32'(gq[i]), 32'(exp_order[i]));
    step(); step();

    // backpressure: result held, no grants while stalled
    set_req(2, 3'd5, 8'hAA, 8'hFF); req_valid_in = 4'b0100; res_ready_in = 1'b0;
    step();
    set_req(0, 3'd6, 8'h5A, 8'h0F); req_valid_in = 4'b0001;
    repeat (3) begin
      step();
      chk("stall_data", 32'(res_data_out), 32'h55);
      chk("stall_id", 32'(res_id_out), 2);
    end
    res_ready_in = 1'b1;
    step();
    req_valid_in = '0;
    step(); step();

    // reserved opcode then NOT
    set_req(1, 3'd7, 8'hFF, 8'hFF); req_valid_in = 4'b0010;
    step();
    chk("rsvd_data", 32'(res_data_out), 0);
    chk("rsvd_err", 32'(res_err_out), 1);
    set_req(1, 3'd2, 8'h0F, 8'h77);
    step();
    req_valid_in = '0;
    chk("not_data", 32'(res_data_out), 32'hF0);
    chk("not_err", 32'(res_err_out), 0);
    step(); step();

    // run the transfer counter up to 0xFFFF then across the wrap
    set_req(3, 3'd1, 8'h81, 8'h18); req_valid_in = 4'b1000;
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      step();
      guard++;
    end
    chk("wrap_bound", 32'(guard < 70000), 1);
    req_valid_in = '0;
    step(); step();
    chk("wrap_count", 32'(op_count_out), 0);

    // reset while holding a stalled result
    set_req(1, 3'd0, 8'hFF, 8'h0F); req_valid_in = 4'b0010;
    step();
    set_req(0, 3'd1, 8'h01, 8'h02); req_valid_in = 4'b0001;
    step();
    req_valid_in = '0; res_ready_in = 1'b0;
    step(); step();
    set_req(0, 3'd0, 8'hF0, 8'h3C); set_req(1, 3'd1, 8'hA0, 8'h05);
    set_req(2, 3'd5, 8'hAA, 8'hFF); set_req(3, 3'd6, 8'hCC, 8'hC3);
    req_valid_in = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(res_valid_out), 0);
    chk("arst_count", 32'(op_count_out), 0);
    chk("arst_data", 32'(res_data_out), 0);
    chk("arst_ready", 32'(req_ready_out), 0);
    sb.delete(); m_full = 1'b0; m_ptr = 0; m_cnt = '0;
    rst_n = 1'b1; res_ready_in = 1'b1; gq.delete();

    // all four requesters continuously valid after reset
    repeat (5) step();
    req_valid_in = '0;
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(gq[i]), 32'(exp_order[i]));
    step(); step();
    chk("final_count", 32'(op_count_out), 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
